// File: rtl/seq_multiplier_n_if.sv
// Handshake and operand bundle between a datapath controller and seq_multiplier_n.
// The controller owns the master side; the multiplier owns the slave side.
interface seq_multiplier_n_if #(
  parameter int WIDTH = 4
);
  logic               enable;
  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] out;

  modport master (
    output enable, start, signed_mode, a, b,
    input  busy, done, out
  );

  modport slave (
    input  enable, start, signed_mode, a, b,
    output busy, done, out
  );
endinterface

// File: rtl/seq_multiplier_n.sv
// Radix-2 shift-add multiplier working on operand magnitudes, with the sign
// re-applied to the full 2*WIDTH-bit product on the final iteration.
module seq_multiplier_n #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic               clk,
  input logic               rst_n,
  seq_multiplier_n_if.slave bus
);

  typedef enum logic {IDLE, CALC} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t               state, state_nxt;
  logic [2*WIDTH-1:0]   acc, acc_nxt;
  logic [WIDTH-1:0]     mcand, mcand_nxt;
  logic [WIDTH-1:0]     mplier, mplier_nxt;
  logic                 neg, neg_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [2*WIDTH-1:0]   out_r, out_nxt;
  logic                 done_r, done_nxt;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   shifted;

  // Every register, done included, is frozen on an edge with enable low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
      out_r  <= '0;
      done_r <= 1'b0;
    end else if (bus.enable) begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
      neg    <= neg_nxt;
      cnt    <= cnt_nxt;
      out_r  <= out_nxt;
      done_r <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    neg_nxt    = neg;
    cnt_nxt    = cnt;
    out_nxt    = out_r;
    done_nxt   = done_r;

    // The carry out of the upper-half add becomes the new MSB after the shift.
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    shifted = mplier[0] ? {sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

    case (state)
      IDLE: begin
        done_nxt = 1'b0;
        if (bus.start) begin
          // -(most negative) wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
          mcand_nxt  = (bus.signed_mode && bus.a[WIDTH-1]) ? -bus.a : bus.a;
          mplier_nxt = (bus.signed_mode && bus.b[WIDTH-1]) ? -bus.b : bus.b;
          neg_nxt    = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          acc_nxt    = '0;
          cnt_nxt    = '0;
          state_nxt  = CALC;
        end
      end
      CALC: begin
        acc_nxt    = shifted;
        mplier_nxt = mplier >> 1;
        cnt_nxt    = cnt + CNT_W'(1);
        if (cnt == LAST) begin
          out_nxt   = neg ? -shifted : shifted;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy = (state == CALC);
  assign bus.done = done_r;
  assign bus.out  = out_r;

endmodule

// File: tb/tb_seq_multiplier_n.sv
// Directed checks of seq_multiplier_n at WIDTH=4 and WIDTH=8 with hand-computed products.
module tb_seq_multiplier_n;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cycles;
  logic sawDone;

  seq_multiplier_n_if #(.WIDTH(4)) bus4 ();
  seq_multiplier_n_if #(.WIDTH(8)) bus8 ();

  seq_multiplier_n #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  seq_multiplier_n #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic getDone(input int w);
    return (w == 8) ? bus8.done : bus4.done;
  endfunction

  // Issues one start, scrambles the operands afterwards, and measures the latency.
  task automatic applyStimulus(input int w, input logic sm, input logic [7:0] ta,
                               input logic [7:0] tb, input logic [15:0] expo,
                               input string tag);
    if (w == 8) begin
      bus8.start = 1'b1; bus8.signed_mode = sm; bus8.a = ta; bus8.b = tb;
    end else begin
      bus4.start = 1'b1; bus4.signed_mode = sm; bus4.a = ta[3:0]; bus4.b = tb[3:0];
    end
    tick();
    if (w == 8) begin
      bus8.start = 1'b0; bus8.signed_mode = ~sm; bus8.a = ~ta; bus8.b = ~tb;
      checkOutput({tag, "_busy"}, {31'd0, bus8.busy}, 32'd1);
    end else begin
      bus4.start = 1'b0; bus4.signed_mode = ~sm; bus4.a = ~ta[3:0]; bus4.b = ~tb[3:0];
      checkOutput({tag, "_busy"}, {31'd0, bus4.busy}, 32'd1);
    end
    checkOutput({tag, "_done0"}, {31'd0, getDone(w)}, 32'd0);
    cycles = 0;
    while (!getDone(w) && cycles < 40) begin
      tick();
      cycles++;
    end
    checkOutput({tag, "_lat"}, cycles, w);
    if (w == 8) checkOutput({tag, "_out"}, {16'd0, bus8.out}, {16'd0, expo});
    else        checkOutput({tag, "_out"}, {24'd0, bus4.out}, {24'd0, expo[7:0]});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk    = 1'b0;
    rst_n  = 1'b0;
    bus4.enable = 1'b1; bus4.start = 1'b0; bus4.signed_mode = 1'b0; bus4.a = '0; bus4.b = '0;
    bus8.enable = 1'b1; bus8.start = 1'b0; bus8.signed_mode = 1'b0; bus8.a = '0; bus8.b = '0;
    tick();
    tick();
    checkOutput("rst_busy4", {31'd0, bus4.busy}, 32'd0);
    checkOutput("rst_done4", {31'd0, bus4.done}, 32'd0);
    checkOutput("rst_out4", {24'd0, bus4.out}, 32'd0);
    checkOutput("rst_busy8", {31'd0, bus8.busy}, 32'd0);
    checkOutput("rst_out8", {16'd0, bus8.out}, 32'd0);
    rst_n = 1'b1;

    applyStimulus(4, 1'b0, 8'd7, 8'd8, 16'h38, "u7x8");
    tick();
    checkOutput("hold_done", {31'd0, bus4.done}, 32'd0);
    checkOutput("hold_busy", {31'd0, bus4.busy}, 32'd0);
    checkOutput("hold_out", {24'd0, bus4.out}, 32'h38);

    // Consecutive calls land start on the done cycle, exercising back-to-back issue.
    applyStimulus(4, 1'b0, 8'd5, 8'd5, 16'd25, "u5x5");
    applyStimulus(4, 1'b0, 8'd3, 8'd0, 16'd0, "u3x0");
    applyStimulus(4, 1'b0, 8'd6, 8'd4, 16'd24, "u6x4");
    applyStimulus(4, 1'b0, 8'd2, 8'd15, 16'd30, "u2x15");
    applyStimulus(4, 1'b0, 8'd13, 8'd11, 16'h8F, "u13x11");
    applyStimulus(4, 1'b1, 8'hD, 8'h5, 16'hF1, "sm3x5");
    applyStimulus(4, 1'b1, 8'h8, 8'h8, 16'h40, "sm8xm8");
    applyStimulus(4, 1'b1, 8'h8, 8'h7, 16'hC8, "sm8x7");
    applyStimulus(4, 1'b0, 8'hD, 8'h5, 16'd65, "uDx5");
    applyStimulus(4, 1'b0, 8'h8, 8'h8, 16'd64, "u8x8");
    applyStimulus(4, 1'b0, 8'h8, 8'h7, 16'd56, "u8x7");
    tick();

    bus4.start = 1'b1; bus4.signed_mode = 1'b0; bus4.a = 4'd5; bus4.b = 4'd3;
    tick();
    bus4.start = 1'b0;
    tick();
    tick();
    bus4.enable = 1'b0;
    repeat (3) tick();
    checkOutput("stall_busy", {31'd0, bus4.busy}, 32'd1);
    checkOutput("stall_done", {31'd0, bus4.done}, 32'd0);
    bus4.enable = 1'b1;
    cycles = 0;
    while (!bus4.done && cycles < 40) begin tick(); cycles++; end
    checkOutput("stall_lat", cycles, 32'd2);
    checkOutput("stall_out", {24'd0, bus4.out}, 32'd15);
    tick();

    bus4.start = 1'b1; bus4.a = 4'd3; bus4.b = 4'd4;
    tick();
    bus4.start = 1'b0;
    tick();
    bus4.start = 1'b1; bus4.a = 4'd15; bus4.b = 4'd15;
    tick();
    bus4.start = 1'b0;
    cycles = 0;
    while (!bus4.done && cycles < 40) begin tick(); cycles++; end
    checkOutput("ign_lat", cycles, 32'd2);
    checkOutput("ign_out", {24'd0, bus4.out}, 32'd12);
    tick();
    checkOutput("ign_noqueue", {31'd0, bus4.busy}, 32'd0);

    applyStimulus(4, 1'b0, 8'd1, 8'd1, 16'd1, "u1x1");
    bus4.enable = 1'b0;
    tick();
    tick();
    checkOutput("en0_done_held", {31'd0, bus4.done}, 32'd1);
    bus4.enable = 1'b1;
    tick();
    checkOutput("en1_done_clr", {31'd0, bus4.done}, 32'd0);

    bus4.start = 1'b1; bus4.a = 4'd7; bus4.b = 4'd8;
    tick();
    bus4.start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("abort_busy", {31'd0, bus4.busy}, 32'd0);
    checkOutput("abort_done", {31'd0, bus4.done}, 32'd0);
    checkOutput("abort_out", {24'd0, bus4.out}, 32'd0);
    sawDone = 1'b0;
    repeat (6) begin tick(); sawDone = sawDone | bus4.done; end
    checkOutput("abort_nodone", {31'd0, sawDone}, 32'd0);

    applyStimulus(4, 1'b0, 8'd2, 8'd15, 16'd30, "pre_rst");
    tick();
    bus4.enable = 1'b0;
    rst_n = 1'b0;
    tick();
    checkOutput("rst_en0_out", {24'd0, bus4.out}, 32'd0);
    rst_n = 1'b1;
    bus4.enable = 1'b1;
    applyStimulus(4, 1'b0, 8'd2, 8'd15, 16'd30, "post_rst");
    tick();

    applyStimulus(8, 1'b0, 8'hFF, 8'hFF, 16'hFE01, "w8_u255x255");
    applyStimulus(8, 1'b1, 8'h80, 8'h80, 16'h4000, "w8_sm128xm128");
    applyStimulus(8, 1'b1, 8'hFF, 8'h7F, 16'hFF81, "w8_sm1x127");
    applyStimulus(8, 1'b0, 8'd0, 8'd200, 16'd0, "w8_u0x200");
    applyStimulus(8, 1'b1, 8'd100, 8'hFD, 16'hFED4, "w8_s100xm3");
    applyStimulus(8, 1'b0, 8'h80, 8'h80, 16'h4000, "w8_u128x128");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
